// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the MAR/MDR memory responder.
// Optional feature macro: MEM_PARITY_EN (parity bit per stored word).
package mem_pkg;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    RELEASE
  } state_t;

  // Even parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [WORD_WIDTH-1:0] word);
    return ^word;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side MAR/MDR request/response bundle for mem_responder.
// Optional feature macro: MEM_PARITY_EN adds par_inject.
interface mem_responder_if;
  import mem_pkg::*;

  logic [WORD_WIDTH-1:0] mar_addr;
  logic [WORD_WIDTH-1:0] mdr_wdata;
  logic                  read;
  logic                  write;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  done;
  logic                  busy;
  logic                  err;
`ifdef MEM_PARITY_EN
  logic                  par_inject;

  modport master (output mar_addr, mdr_wdata, read, write, par_inject,
                  input  rdata, done, busy, err);
  modport slave  (input  mar_addr, mdr_wdata, read, write, par_inject,
                  output rdata, done, busy, err);
`else
  modport master (output mar_addr, mdr_wdata, read, write,
                  input  rdata, done, busy, err);
  modport slave  (input  mar_addr, mdr_wdata, read, write,
                  output rdata, done, busy, err);
`endif
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM: write enable, registered read, no reset.
// Width is chosen by the instantiating block (MEM_PARITY_EN adds one bit).
module mem_array #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write and read-register update on the same port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder behind the MAR/MDR interface: accepts a
// read/write request, waits WAIT_STATES cycles, performs the access, pulses
// done, then waits for the request to drop before returning to IDLE.
// Optional feature macro: MEM_PARITY_EN (stored parity, checked on read).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             clr,
  mem_responder_if.slave  bus
);
`ifdef MEM_PARITY_EN
  localparam int ARR_W = WORD_WIDTH + 1;
`else
  localparam int ARR_W = WORD_WIDTH;
`endif

  state_t state, next;
  logic [31:0] cnt;
  logic accept, enter_done, req_bad;

  logic [ADDR_WIDTH-1:0] addr_q, acc_addr;
  logic [WORD_WIDTH-1:0] wdata_q, acc_wdata;
  logic wr_q, bad_q, acc_wr, acc_bad;

  logic ram_we, ram_re;
  logic [ARR_W-1:0] ram_wdata, ram_rdata;

  logic rdata_sel, err_q, done_q, busy_q;
`ifdef MEM_PARITY_EN
  logic inj_q, acc_inj, chk_q;
`endif

  // Dual request or any address bit above the array range is an error access.
  always_comb begin
    req_bad = (bus.read & bus.write) | (bus.mar_addr[WORD_WIDTH-1:ADDR_WIDTH] != '0);
  end

  // Next-state logic and access strobes.
  always_comb begin
    next       = state;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.read | bus.write) begin
          accept = 1'b1;
          next   = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT:    if (cnt == '0) next = DONE;
      DONE:    next = RELEASE;
      RELEASE: if (!bus.read && !bus.write) next = IDLE;
      default: next = IDLE;
    endcase
    if (next == DONE && state != DONE) enter_done = 1'b1;
  end

  // With no wait states the access happens on the accepting edge itself,
  // so the live bus inputs feed the array instead of the captured copies.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = bus.mar_addr[ADDR_WIDTH-1:0];
      acc_wdata = bus.mdr_wdata;
      acc_wr    = bus.write;
      acc_bad   = req_bad;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wr    = wr_q;
      acc_bad   = bad_q;
    end
`ifdef MEM_PARITY_EN
    acc_inj   = (state == IDLE) ? bus.par_inject : inj_q;
    ram_wdata = {even_parity(acc_wdata) ^ acc_inj, acc_wdata};
`else
    ram_wdata = acc_wdata;
`endif
    ram_we = enter_done & acc_wr & ~acc_bad;
    ram_re = enter_done & ~acc_wr & ~acc_bad;
  end

  // State register and wait-state down-counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      if (accept)
        cnt <= (WAIT_STATES > 0) ? 32'(WAIT_STATES - 1) : '0;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 32'd1;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
`ifdef MEM_PARITY_EN
      inj_q   <= 1'b0;
`endif
    end else if (accept) begin
      addr_q  <= bus.mar_addr[ADDR_WIDTH-1:0];
      wdata_q <= bus.mdr_wdata;
      wr_q    <= bus.write;
      bad_q   <= req_bad;
`ifdef MEM_PARITY_EN
      inj_q   <= bus.par_inject;
`endif
    end
  end

  // Status registers: done pulse, busy span, error and read-data source.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_sel <= 1'b0;
`ifdef MEM_PARITY_EN
      chk_q     <= 1'b0;
`endif
    end else begin
      done_q <= enter_done;
      if (accept) begin
        busy_q <= 1'b1;
        err_q  <= 1'b0;
`ifdef MEM_PARITY_EN
        chk_q  <= 1'b0;
`endif
      end else if (state == RELEASE && next == IDLE) begin
        busy_q <= 1'b0;
      end
      if (enter_done) begin
        if (acc_bad) begin
          err_q     <= 1'b1;
          rdata_sel <= 1'b0;
        end else if (!acc_wr) begin
          err_q     <= 1'b0;
          rdata_sel <= 1'b1;
`ifdef MEM_PARITY_EN
          chk_q     <= 1'b1;
`endif
        end
      end
    end
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (ARR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (acc_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read data comes straight from the array's read register, masked to zero
  // after reset or an error access; parity is checked on that register.
  always_comb begin
    bus.rdata = rdata_sel ? ram_rdata[WORD_WIDTH-1:0] : '0;
    bus.done  = done_q;
    bus.busy  = busy_q;
`ifdef MEM_PARITY_EN
    bus.err   = err_q | (chk_q & (even_parity(ram_rdata[WORD_WIDTH-1:0]) != ram_rdata[WORD_WIDTH]));
`else
    bus.err   = err_q;
`endif
  end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_STATES=2 main instance plus a
// WAIT_STATES=0 instance for latency). Parity cases run with MEM_PARITY_EN.
module tb_mem_responder;
  localparam int WS2 = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if b2();
  mem_responder_if b0();

  mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(WS2)) dut  (.clk(clk), .clr(clr), .bus(b2));
  mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0))   dut0 (.clk(clk), .clr(clr), .bus(b0));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain word array plus the last value shown on rdata.
  logic [31:0] mem_m [512];
  logic [31:0] last_rd = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];
  logic [31:0] pool [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] er,
                                output logic ee);
    if ((rd && wr) || (addr >> 9) != 0) begin
      er = '0; ee = 1'b1; last_rd = '0;
    end else if (wr) begin
      mem_m[addr[8:0]] = data; er = last_rd; ee = 1'b0;
    end else begin
      er = mem_m[addr[8:0]]; last_rd = er; ee = 1'b0;
    end
  endfunction

  // One full access on the WAIT_STATES=2 instance; checks latency, single
  // done pulse, busy span and that rdata/err hold after release.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic inj, input int hold,
                        output logic [31:0] rd_o, output logic err_o);
    int n;
    int pulses;
    bit got;
    b2.read = rd; b2.write = wr; b2.mar_addr = addr; b2.mdr_wdata = data;
`ifdef MEM_PARITY_EN
    b2.par_inject = inj;
`else
    if (inj) $display("note: parity inject ignored without parity build");
`endif
    n = 0; got = 1'b0; pulses = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (b2.done) begin
        got = 1'b1; pulses++;
      end else begin
        b2.mar_addr = $urandom; b2.mdr_wdata = $urandom;
      end
    end
    chk("latency", got ? n : 0, WS2 + 1);
    rd_o = b2.rdata; err_o = b2.err;
    chk("busy_at_done", {31'b0, b2.busy}, 1);
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (b2.done) pulses++;
      chk("busy_held", {31'b0, b2.busy}, 1);
    end
    b2.read = 1'b0; b2.write = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (b2.done) pulses++;
    end while (b2.busy && n < 6);
    chk("busy_release", {31'b0, b2.busy}, 0);
    chk("done_pulses", pulses, 1);
    chk("rdata_hold", b2.rdata, rd_o);
    chk("err_hold", {31'b0, b2.err}, {31'b0, err_o});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ro, er, a, d;
    logic eo, ee, rd, wr;
    int unsigned sel;
    int n;
    bit got;

    b2.read = 0; b2.write = 0; b2.mar_addr = '0; b2.mdr_wdata = '0;
    b0.read = 0; b0.write = 0; b0.mar_addr = '0; b0.mdr_wdata = '0;
`ifdef MEM_PARITY_EN
    b2.par_inject = 0; b0.par_inject = 0;
`endif

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 1, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, 0, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2, 32'hCAFE_F00D, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0005, 32'h0,         4, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h8000_0005, 32'h0,         0, 32'h0,         1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_01FF, 32'h0BAD_F00D, 0, 32'h0,         1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0,         0, 32'h0BAD_F00D, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         0, 32'h55AA_55AA, 1'b0};

    pool[0] = 32'h000; pool[1] = 32'h005; pool[2] = 32'h010; pool[3] = 32'h1FF;
    for (int unsigned i = 4; i < 16; i++) pool[i] = (i * 37 + 3) % 512;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", b2.rdata, 0);
    chk("rst_done", {31'b0, b2.done}, 0);
    chk("rst_busy", {31'b0, b2.busy}, 0);
    chk("rst_err", {31'b0, b2.err}, 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int unsigned i = 0; i < 12; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, er, ee);
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].hold, ro, eo);
      chk("tbl_rdata", ro, tbl[i].exp_rd);
      chk("tbl_err", {31'b0, eo}, {31'b0, tbl[i].exp_err});
    end

    // Reset while waiting on a write: outputs clear at once, no array write
    b2.write = 1'b1; b2.mar_addr = 32'h010; b2.mdr_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mid_busy", {31'b0, b2.busy}, 1);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, b2.busy}, 0);
    chk("mid_rst_rdata", b2.rdata, 0);
    chk("mid_rst_done", {31'b0, b2.done}, 0);
    chk("mid_rst_err", {31'b0, b2.err}, 0);
    b2.write = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;
    model(1'b1, 1'b0, 32'h010, 32'h0, er, ee);
    access(1'b1, 1'b0, 32'h010, 32'h0, 1'b0, 0, ro, eo);
    chk("after_rst_rdata", ro, 32'h55AA_55AA);
    chk("after_rst_err", {31'b0, eo}, 0);

    // Populate the random address pool
    for (int unsigned i = 0; i < 16; i++) begin
      d = $urandom;
      model(1'b0, 1'b1, pool[i], d, er, ee);
      access(1'b0, 1'b1, pool[i], d, 1'b0, 0, ro, eo);
      chk("init_err", {31'b0, eo}, {31'b0, ee});
    end

    // Randomized accesses against the model
    for (int unsigned i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 15)];
      d = $urandom;
      rd = (sel < 4) || (sel == 8);
      wr = (sel >= 4 && sel < 9);
      if (sel == 9) begin
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
        a = a | (32'h1 << $urandom_range(9, 31));
      end
      model(rd, wr, a, d, er, ee);
      access(rd, wr, a, d, 1'b0, $urandom_range(0, 2), ro, eo);
      chk("rnd_rdata", ro, er);
      chk("rnd_err", {31'b0, eo}, {31'b0, ee});
    end

`ifdef MEM_PARITY_EN
    model(1'b0, 1'b1, 32'h020, 32'h1, er, ee);
    access(1'b0, 1'b1, 32'h020, 32'h1, 1'b1, 0, ro, eo);
    model(1'b1, 1'b0, 32'h020, 32'h0, er, ee);
    access(1'b1, 1'b0, 32'h020, 32'h0, 1'b0, 0, ro, eo);
    chk("par_bad_rdata", ro, 32'h1);
    chk("par_bad_err", {31'b0, eo}, 1);
    model(1'b0, 1'b1, 32'h020, 32'h1, er, ee);
    access(1'b0, 1'b1, 32'h020, 32'h1, 1'b0, 0, ro, eo);
    model(1'b1, 1'b0, 32'h020, 32'h0, er, ee);
    access(1'b1, 1'b0, 32'h020, 32'h0, 1'b0, 0, ro, eo);
    chk("par_ok_rdata", ro, 32'h1);
    chk("par_ok_err", {31'b0, eo}, 0);
`endif

    // Zero-wait-state instance: write then read, done one edge after acceptance
    for (int unsigned p = 0; p < 2; p++) begin
      b0.write = (p == 0); b0.read = (p == 1);
      b0.mar_addr = 32'h7; b0.mdr_wdata = 32'hA5A5_A5A5;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
        @(posedge clk); #1;
        n++;
        got = b0.done;
      end
      chk("ws0_latency", got ? n : 0, 1);
      chk("ws0_err", {31'b0, b0.err}, 0);
      if (p == 1) chk("ws0_rdata", b0.rdata, 32'hA5A5_A5A5);
      b0.read = 1'b0; b0.write = 1'b0;
      @(posedge clk); #1;
      chk("ws0_done_low", {31'b0, b0.done}, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("ws0_idle", {31'b0, b0.busy}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
